// File: rtl/lock_pkg.sv
// Shared constants for the combination lock: status encodings, key codes,
// FSM state encodings and small decode helpers.
package lock_pkg;

  // Lock status as seen by the display driver; bit 1 drives the unlock solenoid.
  localparam logic [1:0] ST_LOCKED  = 2'b00;
  localparam logic [1:0] ST_LOCKOUT = 2'b01;
  localparam logic [1:0] ST_OPEN    = 2'b10;

  // Control keys from the keypad scanner.
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_PROG  = 4'hF;

  // FSM state encoding.
  localparam logic [1:0] S_LOCKED  = 2'd0;
  localparam logic [1:0] S_OPEN    = 2'd1;
  localparam logic [1:0] S_PROGRAM = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  // Keycodes 0-9 are digits.
  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  // PROGRAM keeps the unlock asserted, so it reports OPEN.
  function automatic logic [1:0] status_of(input logic [1:0] state);
    logic [1:0] st;
    st = ST_LOCKED;
    case (state)
      S_OPEN, S_PROGRAM: st = ST_OPEN;
      S_LOCKOUT:         st = ST_LOCKOUT;
      default:           st = ST_LOCKED;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN, PROGRAM and LOCKOUT states.
// Ports: clock/reset; i_load strobes i_load_val into the counter; i_run
// enables the count-down; o_expired_c is high while running and at zero.
module lock_timer #(
  parameter int unsigned TW = 26
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_run,
  input  logic [TW-1:0] i_load_val,
  output logic          o_expired_c
);

  logic [TW-1:0] r_cnt;

  // Load has priority; the count saturates at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_expired_c = i_run && (r_cnt == '0);

endmodule

// File: rtl/comb_lock_fsm.sv
// Combination-lock controller: collects keypad digits, compares them with a
// reprogrammable code, opens for a timed window and locks out after repeated
// failures.
// Ports: clock/reset (async active-high); new_key/keycode from the keypad
// scanner; status (00 locked, 01 lockout, 10 open) and count (digits entered)
// to the display driver. All outputs are registered.
module comb_lock_fsm
  import lock_pkg::*;
#(
  parameter int unsigned          CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE  = 16'h1234,
  parameter int unsigned          OPEN_CYCLES    = 25_000_000,
  parameter int unsigned          LOCKOUT_CYCLES = 50_000_000,
  parameter int unsigned          MAX_FAILS      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_key,
  input  logic [3:0] keycode,
  output logic [1:0] status,
  output logic [3:0] count
);

  localparam int unsigned EW      = 4 * CODE_LEN;
  localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int unsigned MAX_CYC = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]     OPEN_LOAD    = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0]     LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]        LEN4         = 4'(CODE_LEN);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAILS);

  logic [1:0]        r_state, w_state_nxt;
  logic [1:0]        r_status;
  logic [3:0]        r_count, w_count_nxt;
  logic [EW-1:0]     r_entry, w_entry_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic [FAIL_W-1:0] r_fails, w_fails_nxt;
  logic [EW-1:0]     r_code, w_code_nxt;

  logic              w_load;
  logic [TW-1:0]     w_load_val;
  logic              w_run;
  logic              w_expired;

  logic              w_full;
  logic              w_match;
  logic [FAIL_W-1:0] w_fails_inc;
  logic [EW-1:0]     w_cap_entry;
  logic [3:0]        w_cap_count;
  logic              w_cap_ovf;

  // Digit capture shared by LOCKED and PROGRAM: shift in, or flag overflow once full.
  assign w_full      = (r_count == LEN4);
  assign w_cap_entry = w_full ? r_entry : EW'({r_entry, keycode});
  assign w_cap_count = w_full ? r_count : r_count + 4'd1;
  assign w_cap_ovf   = r_ovf | w_full;

  assign w_match     = w_full && !r_ovf && (r_entry == r_code);
  assign w_fails_inc = r_fails + FAIL_W'(1);
  assign w_run       = (r_state != S_LOCKED);

  lock_timer #(
    .TW(TW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_run      (w_run),
    .i_load_val (w_load_val),
    .o_expired_c(w_expired)
  );

  // Next-state and datapath; expiry is checked before keys so it always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_entry_nxt = r_entry;
    w_ovf_nxt   = r_ovf;
    w_fails_nxt = r_fails;
    w_code_nxt  = r_code;
    w_load      = 1'b0;
    w_load_val  = OPEN_LOAD;

    case (r_state)
      S_LOCKED: begin
        if (new_key) begin
          if (is_digit(keycode)) begin
            w_entry_nxt = w_cap_entry;
            w_count_nxt = w_cap_count;
            w_ovf_nxt   = w_cap_ovf;
          end else if (keycode == KEY_CLEAR) begin
            w_entry_nxt = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
          end else if (keycode == KEY_ENTER) begin
            w_entry_nxt = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
            if (w_match) begin
              w_state_nxt = S_OPEN;
              w_fails_nxt = '0;
              w_load      = 1'b1;
            end else if (w_fails_inc == FAIL_LIMIT) begin
              w_state_nxt = S_LOCKOUT;
              w_fails_nxt = '0;
              w_load      = 1'b1;
              w_load_val  = LOCKOUT_LOAD;
            end else begin
              w_fails_nxt = w_fails_inc;
            end
          end
        end
      end

      S_OPEN: begin
        if (w_expired) begin
          w_state_nxt = S_LOCKED;
        end else if (new_key) begin
          if (keycode == KEY_ENTER) begin
            w_state_nxt = S_LOCKED;
          end else if (keycode == KEY_PROG) begin
            w_state_nxt = S_PROGRAM;
            w_entry_nxt = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
            w_load      = 1'b1;
          end else if (is_digit(keycode) || (keycode == KEY_CLEAR)) begin
            w_load = 1'b1;
          end
        end
      end

      S_PROGRAM: begin
        if (w_expired) begin
          w_state_nxt = S_LOCKED;
          w_entry_nxt = '0;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end else if (new_key) begin
          if (is_digit(keycode)) begin
            w_entry_nxt = w_cap_entry;
            w_count_nxt = w_cap_count;
            w_ovf_nxt   = w_cap_ovf;
            w_load      = 1'b1;
          end else if ((keycode == KEY_ENTER) || (keycode == KEY_CLEAR)) begin
            if ((keycode == KEY_ENTER) && w_full && !r_ovf) begin
              w_code_nxt = r_entry;
            end
            w_state_nxt = S_OPEN;
            w_entry_nxt = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
            w_load      = 1'b1;
          end
        end
      end

      default: begin
        if (w_expired) begin
          w_state_nxt = S_LOCKED;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_LOCKED;
      r_status <= ST_LOCKED;
      r_count  <= '0;
      r_entry  <= '0;
      r_ovf    <= 1'b0;
      r_fails  <= '0;
      r_code   <= DEFAULT_CODE;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= status_of(w_state_nxt);
      r_count  <= w_count_nxt;
      r_entry  <= w_entry_nxt;
      r_ovf    <= w_ovf_nxt;
      r_fails  <= w_fails_nxt;
      r_code   <= w_code_nxt;
    end
  end

  assign status = r_status;
  assign count  = r_count;

endmodule

// File: tb/tb_comb_lock_fsm.sv
// Directed self-checking bench for comb_lock_fsm with short timer windows.
module tb_comb_lock_fsm;

  logic       clock;
  logic       reset;
  logic       new_key;
  logic [3:0] keycode;
  logic [1:0] status;
  logic [3:0] count;

  int n_asserts = 0;
  int n_fail    = 0;

  comb_lock_fsm #(
    .CODE_LEN      (4),
    .DEFAULT_CODE  (16'h1234),
    .OPEN_CYCLES   (20),
    .LOCKOUT_CYCLES(40),
    .MAX_FAILS     (3)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .new_key(new_key),
    .keycode(keycode),
    .status (status),
    .count  (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called between edges: drive one key pulse, return 1 ns after the sampling edge.
  task automatic press(input logic [3:0] k);
    new_key = 1'b1;
    keycode = k;
    @(posedge clock);
    #1;
    new_key = 1'b0;
    keycode = 4'h0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic attempt(input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3);
    press(d0);
    press(d1);
    press(d2);
    press(d3);
    press(4'hE);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    new_key = 1'b0;
    keycode = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_status", 8'(status), 8'h0);
    check("rst_count", 8'(count), 8'h0);
    reset = 1'b0;
    tick(1);

    // 1: correct code opens for exactly 20 cycles
    press(4'h1); check("t1_cnt1", 8'(count), 8'd1);
    press(4'h2); check("t1_cnt2", 8'(count), 8'd2);
    press(4'h3); check("t1_cnt3", 8'(count), 8'd3);
    press(4'h4); check("t1_cnt4", 8'(count), 8'd4);
    press(4'hE);
    check("t1_open", 8'(status), 8'h2);
    check("t1_cnt0", 8'(count), 8'd0);
    tick(19); check("t1_open_last", 8'(status), 8'h2);
    tick(1);  check("t1_relock", 8'(status), 8'h0);

    // 2: three bad attempts lock out for 40 cycles
    attempt(4'h1, 4'h2, 4'h3, 4'h5); check("t2_fail1", 8'(status), 8'h0);
    attempt(4'h1, 4'h2, 4'h3, 4'h5); check("t2_fail2", 8'(status), 8'h0);
    attempt(4'h1, 4'h2, 4'h3, 4'h5); check("t2_lockout", 8'(status), 8'h1);
    press(4'h1);
    check("t2_lo_key_st", 8'(status), 8'h1);
    check("t2_lo_key_cnt", 8'(count), 8'd0);
    press(4'hE); check("t2_lo_enter", 8'(status), 8'h1);
    tick(37); check("t2_lo_last", 8'(status), 8'h1);
    tick(1);  check("t2_lo_end", 8'(status), 8'h0);

    // 3: overflow fails, clear works
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    check("t3_sat", 8'(count), 8'd4);
    press(4'hE); check("t3_ovf_fail", 8'(status), 8'h0);
    press(4'h9); check("t3_cnt9", 8'(count), 8'd1);
    press(4'hC); check("t3_clear", 8'(count), 8'd0);
    attempt(4'h1, 4'h2, 4'h3, 4'h4); check("t3_open", 8'(status), 8'h2);
    press(4'hE); check("t3_relock", 8'(status), 8'h0);

    // 4: reprogram to 0007, then reset restores 1234
    attempt(4'h1, 4'h2, 4'h3, 4'h4); check("t4_open", 8'(status), 8'h2);
    press(4'hF);
    check("t4_prog_st", 8'(status), 8'h2);
    check("t4_prog_cnt0", 8'(count), 8'd0);
    press(4'h0); check("t4_pcnt1", 8'(count), 8'd1);
    press(4'h0); check("t4_pcnt2", 8'(count), 8'd2);
    press(4'h0); check("t4_pcnt3", 8'(count), 8'd3);
    press(4'h7); check("t4_pcnt4", 8'(count), 8'd4);
    press(4'hE);
    check("t4_prog_done", 8'(status), 8'h2);
    check("t4_prog_done_cnt", 8'(count), 8'd0);
    press(4'hE); check("t4_relock", 8'(status), 8'h0);
    attempt(4'h1, 4'h2, 4'h3, 4'h4); check("t4_old_fails", 8'(status), 8'h0);
    attempt(4'h0, 4'h0, 4'h0, 4'h7); check("t4_new_opens", 8'(status), 8'h2);
    pulse_reset();
    check("t4_rst_st", 8'(status), 8'h0);
    attempt(4'h1, 4'h2, 4'h3, 4'h4); check("t4_default_back", 8'(status), 8'h2);
    press(4'hE); check("t4_relock2", 8'(status), 8'h0);

    // 5: periodic keys keep it open; key on the expiry cycle is discarded
    attempt(4'h1, 4'h2, 4'h3, 4'h4); check("t5_open", 8'(status), 8'h2);
    for (int i = 0; i < 7; i++) begin
      tick(14);
      check($sformatf("t5_hold%0d", i), 8'(status), 8'h2);
      press(4'h5);
    end
    tick(19); check("t5_pre_expiry", 8'(status), 8'h2);
    press(4'h5);
    check("t5_expiry_st", 8'(status), 8'h0);
    check("t5_expiry_cnt", 8'(count), 8'd0);

    // 6: async reset mid-entry and mid-lockout
    press(4'h1); press(4'h2); check("t6_cnt2", 8'(count), 8'd2);
    reset = 1'b1;
    #1;
    check("t6_async_cnt", 8'(count), 8'd0);
    check("t6_async_st", 8'(status), 8'h0);
    reset = 1'b0;
    #1;
    attempt(4'h9, 4'h9, 4'h9, 4'h9);
    attempt(4'h9, 4'h9, 4'h9, 4'h9);
    attempt(4'h9, 4'h9, 4'h9, 4'h9);
    check("t6_lockout", 8'(status), 8'h1);
    tick(5);
    reset = 1'b1;
    #1;
    check("t6_async_lo_st", 8'(status), 8'h0);
    check("t6_async_lo_cnt", 8'(count), 8'd0);
    reset = 1'b0;
    #1;
    attempt(4'h1, 4'h2, 4'h3, 4'h4); check("t6_after_rst_open", 8'(status), 8'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
